// File: rtl/pixel_sink.sv
// Pixel-write sink: clips/linearises pixels into a FIFO and arbitrates one framebuffer port
// between scan-out reads, a full-screen clear engine and buffered pixel writes. Option: PIXEL_SINK_FAIRNESS_EN.
module pixel_sink #(
  parameter int DEPTH = 8,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               X_in,
  input  logic [7:0]               Y_in,
  input  logic [11:0]              Color_in,
  input  logic                     writeEn_in,
  input  logic                     clear_req,
  input  logic [11:0]              clear_color,
  output logic                     clear_done,
  input  logic                     rd_req,
  input  logic [16:0]              rd_addr,
  output logic                     rd_grant,
  output logic                     rd_valid,
  output logic [11:0]              rd_data,
  output logic [16:0]              mem_addr,
  output logic [11:0]              mem_wdata,
  output logic                     mem_we,
  input  logic [11:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(H_RES * V_RES - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  logic [16:0]   r_clr_addr;
  logic [11:0]   r_clr_color;
  logic          r_clear_done;
  logic          r_in_valid;
  logic [16:0]   r_in_addr;
  logic [11:0]   r_in_color;
  logic [28:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic [16:0]   r_mem_addr;
  logic [11:0]   r_mem_wdata;
  logic          r_mem_we;
  logic          r_rd_p1;
  logic          r_rd_valid;

  logic          w_in_ok;
  logic [16:0]   w_lin_addr;
  logic          w_full;
  logic          w_empty;
  logic          w_rd_grant;
  logic          w_pop;
  logic          w_push;
  logic [28:0]   w_head;

  assign w_in_ok    = writeEn_in && (X_in < 9'(H_RES)) && (Y_in < 8'(V_RES));
  // Y*320 + X as two shifted copies of Y plus X
  assign w_lin_addr = {1'b0, Y_in, 8'b0} + {3'b0, Y_in, 6'b0} + {8'b0, X_in};

  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_head  = r_fifo[r_rptr];

`ifdef PIXEL_SINK_FAIRNESS_EN
  assign w_rd_grant = rd_req && !reset && !(w_full && (r_state == S_IDLE));
`else
  assign w_rd_grant = rd_req && !reset;
`endif

  assign w_pop  = !w_rd_grant && (r_state == S_IDLE) && !w_empty;
  assign w_push = r_in_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_valid <= 1'b0;
      r_in_addr  <= '0;
      r_in_color <= '0;
    end else begin
      r_in_valid <= w_in_ok;
      r_in_addr  <= w_lin_addr;
      r_in_color <= Color_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_fifo[r_wptr] <= {r_in_addr, r_in_color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (r_in_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_clr_addr   <= '0;
      r_clr_color  <= '0;
      r_clear_done <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      r_mem_we     <= 1'b0;
      r_rd_p1      <= w_rd_grant;
      r_rd_valid   <= r_rd_p1;
      if (w_rd_grant) begin
        r_mem_addr <= rd_addr;
      end else if (r_state == S_CLEAR) begin
        r_mem_addr  <= r_clr_addr;
        r_mem_wdata <= r_clr_color;
        r_mem_we    <= 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          r_state      <= S_IDLE;
          r_clear_done <= 1'b1;
        end else begin
          r_clr_addr <= r_clr_addr + 17'd1;
        end
      end else if (w_pop) begin
        r_mem_addr  <= w_head[28:12];
        r_mem_wdata <= w_head[11:0];
        r_mem_we    <= 1'b1;
      end
      if ((r_state == S_IDLE) && clear_req) begin
        r_state     <= S_CLEAR;
        r_clr_addr  <= '0;
        r_clr_color <= clear_color;
      end
    end
  end

  assign clear_done = r_clear_done;
  assign rd_grant   = w_rd_grant;
  assign rd_valid   = r_rd_valid;
  // RAM data is only meaningful on the rd_valid cycle; hold zero otherwise
  assign rd_data    = r_rd_valid ? mem_rdata : '0;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: stimulus pushes expected writes/reads, a negedge monitor pops and compares.
module tb_pixel_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  X_in;
  logic [7:0]  Y_in;
  logic [11:0] Color_in;
  logic        writeEn_in;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_done;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_grant;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata = '0;
  logic [3:0]  fifo_level;
  logic        overflow;

  pixel_sink #(.DEPTH(8), .H_RES(320), .V_RES(240)) dut (
    .clk(clk), .reset(reset), .X_in(X_in), .Y_in(Y_in), .Color_in(Color_in),
    .writeEn_in(writeEn_in), .clear_req(clear_req), .clear_color(clear_color),
    .clear_done(clear_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] romf(input logic [16:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  // synchronous-read RAM stand-in with address-derived contents
  always @(posedge clk) mem_rdata <= romf(mem_addr);

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
    int          at;
  } wr_t;

  wr_t         wq[$];
  logic [11:0] rq[$];
  int errors = 0;
  int checks = 0;
  int edges  = 0;
  int done_cnt = 0;
  bit mask = 1'b0;

  always @(posedge clk) edges++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !mask) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr=%0d data=%0h exp=none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
          if (e.at >= 0) chk("wr_latency", edges, e.at);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_valid data=%0h exp=none", rd_data);
        end else begin
          logic [11:0] d;
          d = rq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(d));
        end
      end
      if (clear_done) begin
        done_cnt++;
        chk("clear_done_at_last", {14'd0, mem_we, mem_addr}, {14'd0, 1'b1, 17'd76799});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [11:0] c);
    X_in = 9'(x); Y_in = 8'(y); Color_in = c; writeEn_in = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    chk(nm, 32'(wq.size() + rq.size()), 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    reset = 1'b1; X_in = '0; Y_in = '0; Color_in = '0; writeEn_in = 1'b0;
    clear_req = 1'b0; clear_color = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (2) step();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    reset = 1'b0;
    step();

    // single pixel: write exactly two edges after its sampling edge
    send(10, 2, 12'hF00);
    wq.push_back('{17'd650, 12'hF00, edges + 3});
    step();
    writeEn_in = 1'b0;
    drain("drain_single", 20);

    // out-of-range pixels are dropped silently
    send(320, 0, 12'h0F0); step();
    send(0, 240, 12'h00F); step();
    writeEn_in = 1'b0;
    repeat (4) step();
    chk("clip_level", 32'(fifo_level), 0);
    chk("clip_overflow", 32'(overflow), 0);

`ifndef PIXEL_SINK_FAIRNESS_EN
    // reads hold the port for 12 cycles while 12 pixels stream: 8 buffered, 4 dropped
    rd_addr = 17'd100;
    for (int i = 1; i <= 12; i++) begin
      send(i, i, 12'(i * 12'h111));
      if (i >= 2) begin
        rd_req = 1'b1;
        rq.push_back(romf(17'd100));
      end
      if (i <= 8) wq.push_back('{17'(i * 321), 12'(i * 12'h111), -1});
      step();
    end
    writeEn_in = 1'b0;
    rq.push_back(romf(17'd100));
    step();
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    rd_req = 1'b0;
    drain("drain_overflow", 40);
    chk("ovf_sticky", 32'(overflow), 1);
`endif

    // full FIFO with a held read request
    rd_addr = 17'd200;
    rd_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(20 + i, 100, 12'(12'h800 + i));
      rq.push_back(romf(17'd200));
      wq.push_back('{17'(32000 + 20 + i), 12'(12'h800 + i), -1});
      step();
    end
    writeEn_in = 1'b0;
    rq.push_back(romf(17'd200));
    step();
    chk("fair_level", 32'(fifo_level), 8);
`ifdef PIXEL_SINK_FAIRNESS_EN
    chk("fair_grant", 32'(rd_grant), 0);
`else
    chk("fair_grant", 32'(rd_grant), 1);
    rq.push_back(romf(17'd200));
`endif
    step();
    rq.push_back(romf(17'd200));
    step();
    rd_req = 1'b0;
    drain("drain_fair", 40);

    // full-screen clear, with a pixel queued behind it and an ignored second request
    clear_color = 12'h00F;
    clear_req = 1'b1;
    for (int a = 0; a < 76800; a++) wq.push_back('{17'(a), 12'h00F, -1});
    step();
    clear_req = 1'b0;
    clear_color = 12'hFFF;
    repeat (3) step();
    send(5, 1, 12'h0AB);
    wq.push_back('{17'd325, 12'h0AB, -1});
    step();
    writeEn_in = 1'b0;
    clear_color = 12'h123;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    drain("drain_clear", 80000);
    chk("clear_done_count", 32'(done_cnt), 1);

    // reset in the middle of a clear aborts it
    mask = 1'b1;
    dc = done_cnt;
    clear_color = 12'h0F0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    send(1, 1, 12'h777);
    step();
    writeEn_in = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr >= 17'd1000) && n < 5000) begin
      step();
      n++;
    end
    chk("abort_reached", 32'(n < 5000), 1);
    rd_addr = 17'd7;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    reset = 1'b1;
    step();
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    chk("abort_mem_wdata", 32'(mem_wdata), 0);
    chk("abort_level", 32'(fifo_level), 0);
    chk("abort_overflow", 32'(overflow), 0);
    chk("abort_rd_valid", 32'(rd_valid), 0);
    chk("abort_rd_data", 32'(rd_data), 0);
    chk("abort_clear_done", 32'(clear_done), 0);
    reset = 1'b0;
    mask = 1'b0;
    repeat (6) step();
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    chk("abort_level_after", 32'(fifo_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
